// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FIFO entry layout, fetch FSM
// states and the instruction size used to advance the PC.
package fetch_pkg;

  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order fetch buffer. Entries are allocated at the tail when a request
// fires, filled in order when responses return, and popped at the head by
// decode. Pointers carry one extra wrap bit so full and empty are distinct.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH) + 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         alloc_i,
  input  logic [63:0]  alloc_pc_i,
  input  logic         fill_i,
  input  logic [31:0]  fill_inst_i,
  input  logic         pop_i,
  input  logic         clear_i,
  output logic [PW-1:0] count_o,
  output logic [PW-1:0] unfilled_o,
  output fetch_entry_t head_o
);

  localparam int AW = PW - 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, fill_q;

  // Pointer update; a clear drops every entry, including unfilled ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      if (alloc_i) tail_q <= tail_q + PW'(1);
      if (fill_i)  fill_q <= fill_q + PW'(1);
      if (pop_i)   head_q <= head_q + PW'(1);
    end
  end

  // Per-entry storage; allocation and fill never target the same slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    // Capture the PC on allocation and the instruction word on fill.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        mem_q[gi] <= '0;
      end else if (clear_i) begin
        mem_q[gi].filled <= 1'b0;
      end else if (alloc_i && tail_q[AW-1:0] == AW'(gi)) begin
        mem_q[gi] <= '{pc: alloc_pc_i, inst: 32'h0, filled: 1'b0};
      end else if (fill_i && fill_q[AW-1:0] == AW'(gi)) begin
        mem_q[gi].inst   <= fill_inst_i;
        mem_q[gi].filled <= 1'b1;
      end
    end
  end

  assign count_o    = tail_q - head_q;
  assign unfilled_o = tail_q - fill_q;
  assign head_o     = mem_q[head_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage around an external PC register: computes next PC,
// issues in-order memory reads, buffers responses and hands them to decode.
// Redirects flush the buffer and drop responses still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/stall counters.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [63:0] pc_i,
  output logic [63:0] next_pc_o,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [63:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [PW-1:0] drop_q, drop_d;
  logic [PW-1:0] count, unfilled, outstanding;
  fetch_entry_t  head;
  logic          alloc, fill, pop, clear, head_valid;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk_in),
    .rst_ni      (rst_n_in),
    .alloc_i     (alloc),
    .alloc_pc_i  (pc_i),
    .fill_i      (fill),
    .fill_inst_i (imem_resp_data_i),
    .pop_i       (pop),
    .clear_i     (clear),
    .count_o     (count),
    .unfilled_o  (unfilled),
    .head_o      (head)
  );

  assign head_valid      = (count != '0) && head.filled;
  assign inst_valid_o    = head_valid;
  assign inst_o          = head_valid ? head.inst : 32'h0;
  assign inst_pc_o       = head_valid ? head.pc : 64'h0;
  assign imem_req_addr_o = pc_i;
  // In RUN drop_q is zero and in FLUSH the buffer is empty, so the sum is
  // the number of responses still owed by memory in either state.
  assign outstanding     = unfilled + drop_q;

  // Next-state, next-PC and buffer control; redirect outranks everything.
  always_comb begin
    state_d          = state_q;
    drop_d           = drop_q;
    next_pc_o        = pc_i;
    imem_req_valid_o = 1'b0;
    alloc            = 1'b0;
    fill             = 1'b0;
    pop              = 1'b0;
    clear            = 1'b0;
    unique case (state_q)
      BOOT: begin
        next_pc_o = RESET_PC;
        state_d   = RUN;
      end
      default: begin
        if (redirect_valid_i) begin
          next_pc_o = redirect_pc_i;
          clear     = 1'b1;
          // A response arriving this cycle is already accounted for.
          drop_d    = (imem_resp_valid_i && outstanding != '0) ?
                      outstanding - PW'(1) : outstanding;
          state_d   = (drop_d != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
          if (imem_resp_valid_i && drop_q != '0) drop_d = drop_q - PW'(1);
          if (drop_d == '0) state_d = RUN;
        end else begin
          imem_req_valid_o = count < PW'(DEPTH);
          alloc            = imem_req_valid_o && imem_req_ready_i;
          if (alloc) next_pc_o = pc_i + 64'(INST_BYTES);
          fill             = imem_resp_valid_i && unfilled != '0;
          pop              = head_valid && inst_ready_i;
        end
      end
    endcase
  end

  // FSM state and pending-drop counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= BOOT;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // A response with nothing outstanding is a memory protocol error.
  assert property (@(posedge clk_in) disable iff (!rst_n_in)
    (imem_resp_valid_i && state_q != BOOT) |-> (outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Saturating counts of request fires and decode-starved cycles.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else if (state_q != BOOT) begin
      if (alloc && fetch_cnt_q != '1) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!head_valid && inst_ready_i && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: an external PC register, an in-order
// memory with variable latency, and a transaction-level reference model.
module tb_instr_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [63:0] pc_i = '0;
  logic [63:0] next_pc_o;
  logic        redirect_valid_i = 1'b0;
  logic [63:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [63:0] imem_req_addr_o;
  logic        imem_resp_valid_i = 1'b0;
  logic [31:0] imem_resp_data_i = '0;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_o, stall_cnt_o;
`endif

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .pc_i              (pc_i),
    .next_pc_o         (next_pc_o),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_pc_i     (redirect_pc_i),
    .imem_req_valid_o  (imem_req_valid_o),
    .imem_req_ready_i  (imem_req_ready_i),
    .imem_req_addr_o   (imem_req_addr_o),
    .imem_resp_valid_i (imem_resp_valid_i),
    .imem_resp_data_i  (imem_resp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_ready_i      (inst_ready_i),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt_o       (fetch_cnt_o),
    .stall_cnt_o       (stall_cnt_o)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered entries, pending drops, boot flag.
  typedef struct { logic [63:0] pc; bit filled; } ent_t;
  typedef struct { logic [63:0] addr; int due; } req_t;
  ent_t        mq[$];
  req_t        memq[$];
  logic [63:0] delivered[$];
  int          m_drop = 0;
  bit          m_boot = 1'b1;
  longint      m_fetch = 0, m_stall = 0;
  int          cyc = 0;

  // Stimulus knobs (percent probabilities) and one-shot redirect.
  int          k_ready = 100, k_inst_ready = 100, k_redirect = 0, k_resp = 100, lat = 1;
  bit          force_redir = 1'b0;
  logic [63:0] force_target = '0;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_deliv(input string name, input int idx, input logic [63:0] exp);
    if (idx < delivered.size()) check(name, delivered[idx], exp);
    else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: only %0d delivered, expected pc %h at index %0d",
               name, delivered.size(), exp, idx);
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    redirect_valid_i = 1'b0;
    imem_req_ready_i = 1'b0;
    imem_resp_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    memq.delete();
    mq.delete();
    delivered.delete();
    m_drop = 0;
    m_boot = 1'b1;
    m_fetch = 0;
    m_stall = 0;
    repeat (2) @(posedge clk_in);
    #1;
    check("rst_next_pc", next_pc_o, RESET_PC);
    check("rst_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    check("rst_inst_valid", {63'h0, inst_valid_o}, 64'h0);
    check("rst_inst", {32'h0, inst_o}, 64'h0);
    check("rst_inst_pc", inst_pc_o, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_fetch_cnt", {32'h0, fetch_cnt_o}, 64'h0);
    check("rst_stall_cnt", {32'h0, stall_cnt_o}, 64'h0);
`endif
    pc_i = next_pc_o;
    rst_n_in = 1'b1;
  endtask

  // One clock: drive inputs, compare all outputs against the model at the
  // falling edge, then advance model, memory and PC register.
  task automatic step();
    bit          exp_req, exp_iv, fire_m, resp, act_fire;
    logic [63:0] exp_npc, npc_s, act_addr;
    int          uf;
    imem_req_ready_i = ($urandom_range(0, 99) < k_ready);
    inst_ready_i     = ($urandom_range(0, 99) < k_inst_ready);
    redirect_pc_i    = {$urandom, $urandom} & ~64'h3;
    if (force_redir) begin
      redirect_valid_i = 1'b1;
      redirect_pc_i    = force_target;
      force_redir      = 1'b0;
    end else begin
      redirect_valid_i = ($urandom_range(0, 99) < k_redirect);
    end
    resp = memq.size() > 0 && memq[0].due <= cyc && $urandom_range(0, 99) < k_resp;
    imem_resp_valid_i = resp;
    imem_resp_data_i  = resp ? data_of(memq[0].addr) : $urandom;

    @(negedge clk_in);
    uf = 0;
    foreach (mq[i]) if (!mq[i].filled) uf++;
    exp_iv = mq.size() > 0 && mq[0].filled;
    if (m_boot) begin
      exp_npc = RESET_PC;
      exp_req = 1'b0;
    end else if (redirect_valid_i) begin
      exp_npc = redirect_pc_i;
      exp_req = 1'b0;
    end else if (m_drop > 0) begin
      exp_npc = pc_i;
      exp_req = 1'b0;
    end else begin
      exp_req = mq.size() < DEPTH;
      exp_npc = (exp_req && imem_req_ready_i) ? pc_i + 64'd4 : pc_i;
    end
    fire_m = exp_req && imem_req_ready_i;

    check("req_valid", {63'h0, imem_req_valid_o}, {63'h0, exp_req});
    check("next_pc", next_pc_o, exp_npc);
    if (exp_req) check("req_addr", imem_req_addr_o, pc_i);
    check("inst_valid", {63'h0, inst_valid_o}, {63'h0, exp_iv});
    if (exp_iv) begin
      check("inst_pc", inst_pc_o, mq[0].pc);
      check("inst", {32'h0, inst_o}, {32'h0, data_of(mq[0].pc)});
    end
`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", {32'h0, fetch_cnt_o}, {32'h0, m_fetch[31:0]});
    check("stall_cnt", {32'h0, stall_cnt_o}, {32'h0, m_stall[31:0]});
`endif
    npc_s    = next_pc_o;
    act_fire = imem_req_valid_o && imem_req_ready_i;
    act_addr = imem_req_addr_o;

    if (!m_boot) begin
      if (fire_m) m_fetch++;
      if (!exp_iv && inst_ready_i) m_stall++;
    end
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redirect_valid_i) begin
      m_drop = uf + m_drop;
      if (resp && m_drop > 0) m_drop--;
      mq.delete();
    end else if (m_drop > 0) begin
      if (resp) m_drop--;
    end else begin
      if (resp) begin
        for (int i = 0; i < mq.size(); i++)
          if (!mq[i].filled) begin
            mq[i].filled = 1'b1;
            break;
          end
      end
      if (exp_iv && inst_ready_i) begin
        delivered.push_back(mq[0].pc);
        void'(mq.pop_front());
      end
      if (fire_m) mq.push_back('{pc: pc_i, filled: 1'b0});
    end
    if (resp) void'(memq.pop_front());
    if (act_fire) memq.push_back('{addr: act_addr, due: cyc + lat});

    @(posedge clk_in);
    #1;
    pc_i = npc_s;
    cyc++;
  endtask

  initial begin
    // Fill to capacity with decode stalled, then resume.
    k_ready = 100; k_resp = 100; lat = 1; k_inst_ready = 0; k_redirect = 0;
    do_reset();
    repeat (10) step();
    check("full_next_pc", next_pc_o, 64'h10);
    check("full_req_valid", {63'h0, imem_req_valid_o}, 64'h0);
    check("full_head_pc", inst_pc_o, 64'h0);
    check("full_head_inst", {32'h0, inst_o}, 64'h13);
`ifdef FETCH_PERF_CNT_EN
    check("full_fetch_cnt", {32'h0, fetch_cnt_o}, 64'd4);
`endif
    k_inst_ready = 100;
    repeat (10) step();
    check_deliv("resume_pc0", 0, 64'h0);
    check_deliv("resume_pc1", 1, 64'h4);
    check_deliv("resume_pc2", 2, 64'h8);
    check_deliv("resume_pc4", 4, 64'h10);

    // Redirect with several reads in flight.
    lat = 3;
    repeat (6) step();
    delivered.delete();
    force_redir = 1'b1;
    force_target = 64'h100;
    repeat (15) step();
    check_deliv("redir_pc0", 0, 64'h100);
    check_deliv("redir_pc1", 1, 64'h104);

    // PC increment wraps at the top of the address space.
    lat = 1;
    delivered.delete();
    force_redir = 1'b1;
    force_target = 64'hFFFF_FFFF_FFFF_FFF8;
    repeat (10) step();
    check_deliv("wrap_pc0", 0, 64'hFFFF_FFFF_FFFF_FFF8);
    check_deliv("wrap_pc1", 1, 64'hFFFF_FFFF_FFFF_FFFC);
    check_deliv("wrap_pc2", 2, 64'h0);
    check_deliv("wrap_pc3", 3, 64'h4);

    // Randomized segments, each starting from a mid-operation reset.
    for (int s = 0; s < 8; s++) begin
      k_ready      = $urandom_range(30, 100);
      k_inst_ready = $urandom_range(20, 100);
      k_resp       = $urandom_range(40, 100);
      k_redirect   = $urandom_range(0, 8);
      lat          = $urandom_range(1, 4);
      repeat (350) step();
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage wrapped around the ProgramCounter register.
- Generates the next-PC value fed into the PC register, reading back the registered PC each cycle.
- Issues in-order instruction-memory reads and buffers returned instructions with their PCs in a small FIFO.
- Presents buffered instructions to decode with a valid/ready handshake; handles redirects (branch/jump) by flushing.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of outstanding memory reads (power of 2, ≥2).
- RESET_PC, 64'h0, PC driven on next_pc_o while in reset and in the first cycle after it.

Ports:
- clk_in  in  1  clock, rising-edge.
- rst_n_in  in  1  asynchronous, active-low reset.
- pc_i  in  64  current PC from the ProgramCounter register output.
- next_pc_o  out  64  next PC to the ProgramCounter register input; captured every cycle.
- redirect_valid_i  in  1  taken branch/jump from execute.
- redirect_pc_i  in  64  redirect target.
- imem_req_valid_o  out  1  read request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  64  read address (= pc_i).
- imem_resp_valid_i  in  1  read data valid; in-order, cannot be back-pressured.
- imem_resp_data_i  in  32  instruction word.
- inst_valid_o  out  1  FIFO head valid and filled.
- inst_ready_i  in  1  decode accepts.
- inst_o  out  32  head instruction.
- inst_pc_o  out  64  head PC.

Behaviour:
- Clock/reset: one clock clk_in; reset rst_n_in is asynchronous, active-low.
- Reset values: FSM=BOOT; FIFO empty; drop_cnt=0; imem_req_valid_o=0; inst_valid_o=0; next_pc_o=RESET_PC; inst_o/inst_pc_o=0.
- FSM states and transitions:
  - BOOT: one cycle after reset release. next_pc_o=RESET_PC, no request. Goes to RUN.
  - RUN:
    - imem_req_valid_o=1 when FIFO has a free slot (allocated count < DEPTH) and redirect_valid_i=0.
    - Request fire (valid&ready) allocates a tail entry {pc=pc_i, filled=0}; next_pc_o=pc_i+4 (64-bit wrap, no carry out).
    - No fire: next_pc_o=pc_i.
  - FLUSH: entered when a redirect hits while unfilled entries exist.
    - drop_cnt is loaded with the unfilled count; each imem_resp_valid_i decrements it and its data is discarded.
    - No requests are issued; next_pc_o holds pc_i.
    - Goes to RUN when drop_cnt reaches 0, including the cycle its last response arrives (that request may then issue next cycle).
- Response (RUN): fills the oldest unfilled entry, in order. Latency from response to inst_valid_o is 1 cycle.
- Decode handshake:
  - inst_valid_o=1 iff the head entry is filled.
  - Head pops on valid&ready; inst_o/inst_pc_o hold stable while valid&!ready.
- Redirect (any state except BOOT):
  - next_pc_o=redirect_pc_i that cycle; redirect has priority over fire/pop/fill.
  - All FIFO entries are invalidated; inst_valid_o=0 from the next cycle.
  - A same-cycle request is suppressed.
  - A same-cycle response counts as consumed, so drop_cnt = unfilled − 1 if imem_resp_valid_i.
  - A redirect during FLUSH reloads drop_cnt with the outstanding count.
- Boundaries:
  - Full FIFO: no request; next_pc_o=pc_i.
  - Empty FIFO: inst_valid_o=0.
  - Pop and allocate in the same cycle on a full FIFO is not allowed (allocation checks the pre-pop count).
  - Fill and pop in the same cycle on distinct entries is legal.
  - Response while FIFO has no unfilled entries and drop_cnt=0: ignored (protocol error; assertion).
  - Reset mid-operation: everything returns to reset values immediately, and in-flight responses after reset are ignored. Memory must also be reset.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds 32-bit outputs fetch_cnt_o (request fires) and stall_cnt_o (cycles where inst_valid_o=0 && inst_ready_i=1). Both reset to 0, saturate at 32'hFFFF_FFFF, and do not count in BOOT.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t {pc[63:0], inst[31:0], filled};
  - typedef enum fetch_state_t {BOOT, RUN, FLUSH};
  - localparam INST_BYTES=4.
- Sub-module fetch_fifo: storage plus head/tail/fill pointers with alloc/fill/pop/clear ports. Pointers are log2(DEPTH)+1 bits, wrap naturally.

Test Plan:
- Reset release, memory always ready, 1-cycle response: next_pc_o sequence RESET_PC, 0, 4, 8, ...; inst_pc_o 0, 4, 8 with matching data.
- inst_ready_i=0, DEPTH=4: after 4 fires imem_req_valid_o=0, next_pc_o holds 16, inst_o stable. Raise ready: fetch resumes at 16.
- Redirect to 64'h100 with 2 responses outstanding: next_pc_o=64'h100 that cycle; FSM FLUSH; the 2 responses are dropped; first delivered inst_pc_o=64'h100.
- Redirect in the same cycle as a response with 1 outstanding: no FLUSH entered; next request at the target.
- next_pc_o at 64'hFFFF_FFFF_FFFF_FFFC after fire: wraps to 0.
- With FETCH_PERF_CNT_EN: 10 fires and 3 starved-ready cycles give fetch_cnt_o=10, stall_cnt_o=3.
